// File: rtl/operand_stack_pkg.sv
// rtl/operand_stack_pkg.sv - shared op encodings and trap codes for the operand stack
package operand_stack_pkg;

   // Operation encodings driven by the execute stage
   localparam logic [2:0] STACK_NOP       = 3'd0;
   localparam logic [2:0] STACK_PUSH      = 3'd1;
   localparam logic [2:0] STACK_POP       = 3'd2;
   localparam logic [2:0] STACK_DROP      = 3'd3;
   localparam logic [2:0] STACK_REPLACE   = 3'd4;
   localparam logic [2:0] STACK_POP2_PUSH = 3'd5;
   localparam logic [2:0] STACK_DUP       = 3'd6;

   // Trap codes, shared with the cpu trap port
   localparam logic [2:0] TRAP_NONE            = 3'd0;
   localparam logic [2:0] TRAP_STACK_OVERFLOW  = 3'd1;
   localparam logic [2:0] TRAP_STACK_UNDERFLOW = 3'd2;

endpackage

// File: rtl/operand_stack_ram.sv
// rtl/operand_stack_ram.sv - flop array with one write port and two async read ports
module operand_stack_ram #(
   parameter int WIDTH      = 64,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [DEPTH_LOG2-1:0] raddr_top,
   input  logic [DEPTH_LOG2-1:0] raddr_next,
   output logic [WIDTH-1:0]      rdata_top,
   output logic [WIDTH-1:0]      rdata_next
);

   logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

   // Storage is deliberately not reset; validity is tracked by the count register
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_top  = mem[raddr_top];
   assign rdata_next = mem[raddr_next];

endmodule

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - WebAssembly operand stack with sticky overflow/underflow trap
module operand_stack
   import operand_stack_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            op,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [WIDTH-1:0]      data_in,
   output logic [WIDTH-1:0]      top,
   output logic [WIDTH-1:0]      next,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic [2:0]            trap
);

   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_TWO  = 2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = 1;
   localparam logic [DEPTH_LOG2-1:0] ADDR_TWO = 2;

   logic [DEPTH_LOG2:0]   count_nxt;
   logic [2:0]            trap_nxt;
   logic                  we;
   logic [DEPTH_LOG2-1:0] waddr;
   logic [WIDTH-1:0]      wdata;
   logic [DEPTH_LOG2-1:0] addr_push;
   logic [DEPTH_LOG2-1:0] addr_top;
   logic [DEPTH_LOG2-1:0] addr_next;
   logic [WIDTH-1:0]      rdata_top;
   logic [WIDTH-1:0]      rdata_next;
   logic                  has_one;
   logic                  has_two;

   // Low bits of count address the next free slot; at full they wrap to 0,
   // which is harmless because writes are blocked there
   assign addr_push = count[DEPTH_LOG2-1:0];
   assign addr_top  = addr_push - ADDR_ONE;
   assign addr_next = addr_push - ADDR_TWO;

   assign has_one  = (count >= CNT_ONE);
   assign has_two  = (count >= CNT_TWO);
   assign empty    = (count == '0);
   assign full     = (count == CNT_FULL);
   assign op_ready = (trap == TRAP_NONE);

   assign top  = has_one ? rdata_top  : '0;
   assign next = has_two ? rdata_next : '0;

   operand_stack_ram #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk        (clk),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .raddr_top  (addr_top),
      .raddr_next (addr_next),
      .rdata_top  (rdata_top),
      .rdata_next (rdata_next)
   );

   // Decode the op, check its minimum/maximum count, and pick write and next-state
   always_comb begin
      we        = 1'b0;
      waddr     = addr_push;
      wdata     = data_in;
      count_nxt = count;
      trap_nxt  = trap;
      if (op_valid && (trap == TRAP_NONE)) begin
         case (op)
            STACK_PUSH: begin
               if (full) begin
                  trap_nxt = TRAP_STACK_OVERFLOW;
               end else begin
                  we        = 1'b1;
                  count_nxt = count + CNT_ONE;
               end
            end
            STACK_POP, STACK_DROP: begin
               if (!has_one) begin
                  trap_nxt = TRAP_STACK_UNDERFLOW;
               end else begin
                  count_nxt = count - CNT_ONE;
               end
            end
            STACK_REPLACE: begin
               if (!has_one) begin
                  trap_nxt = TRAP_STACK_UNDERFLOW;
               end else begin
                  we    = 1'b1;
                  waddr = addr_top;
               end
            end
            STACK_POP2_PUSH: begin
               if (!has_two) begin
                  trap_nxt = TRAP_STACK_UNDERFLOW;
               end else begin
                  we        = 1'b1;
                  waddr     = addr_next;
                  count_nxt = count - CNT_ONE;
               end
            end
            STACK_DUP: begin
               // Empty is checked first so DUP on an empty stack is an underflow
               if (!has_one) begin
                  trap_nxt = TRAP_STACK_UNDERFLOW;
               end else if (full) begin
                  trap_nxt = TRAP_STACK_OVERFLOW;
               end else begin
                  we        = 1'b1;
                  wdata     = rdata_top;
                  count_nxt = count + CNT_ONE;
               end
            end
            default: begin
               we = 1'b0;
            end
         endcase
      end
   end

   // Count and sticky trap registers; only reset clears a latched trap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         trap  <= TRAP_NONE;
      end else begin
         count <= count_nxt;
         trap  <= trap_nxt;
      end
   end

endmodule

// File: tb/tb_operand_stack.sv
// tb/tb_operand_stack.sv - directed self-checking bench for operand_stack
module tb_operand_stack;
   import operand_stack_pkg::*;

   logic        clk;
   logic        reset;
   logic [2:0]  op;
   logic        op_valid;
   logic        op_ready;
   logic [63:0] data_in;
   logic [63:0] top;
   logic [63:0] next;
   logic [4:0]  count;
   logic        empty;
   logic        full;
   logic [2:0]  trap;

   int n_cmp;
   int n_bad;

   operand_stack #(.WIDTH(64), .DEPTH_LOG2(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .op       (op),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .data_in  (data_in),
      .top      (top),
      .next     (next),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .trap     (trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] o, input logic [63:0] d);
      @(negedge clk);
      op       = o;
      data_in  = d;
      op_valid = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic do_op(input logic [2:0] o, input logic [63:0] d);
      drive(o, d);
      step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      op_valid = 1'b0;
      reset    = 1'b0;
      #2;
      reset    = 1'b1;
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      reset    = 1'b0;
      op       = STACK_NOP;
      op_valid = 1'b0;
      data_in  = '0;
      #12;
      expect_eq("rst_count",    64'(count),    64'd0);
      expect_eq("rst_empty",    64'(empty),    64'd1);
      expect_eq("rst_full",     64'(full),     64'd0);
      expect_eq("rst_op_ready", 64'(op_ready), 64'd1);
      expect_eq("rst_trap",     64'(trap),     64'd0);
      expect_eq("rst_top",      top,           64'd0);
      expect_eq("rst_next",     next,          64'd0);
      @(negedge clk);
      reset = 1'b1;

      // push then drop
      do_op(STACK_PUSH, 64'h2A);
      expect_eq("push_top",   top,        64'h2A);
      expect_eq("push_count", 64'(count), 64'd1);
      expect_eq("push_empty", 64'(empty), 64'd0);
      do_op(STACK_DROP, 64'h0);
      expect_eq("drop_count", 64'(count), 64'd0);
      expect_eq("drop_empty", 64'(empty), 64'd1);
      expect_eq("drop_top",   top,        64'd0);
      expect_eq("drop_trap",  64'(trap),  64'd0);

      // binary op
      do_op(STACK_PUSH, 64'd5);
      do_op(STACK_PUSH, 64'd7);
      drive(STACK_POP2_PUSH, 64'd12);
      #1;
      expect_eq("bin_pre_top",  top,  64'd7);
      expect_eq("bin_pre_next", next, 64'd5);
      step();
      expect_eq("bin_count", 64'(count), 64'd1);
      expect_eq("bin_top",   top,        64'd12);
      expect_eq("bin_next",  next,       64'd0);

      // op_valid low and reserved op leave state alone
      drive(STACK_PUSH, 64'd99);
      op_valid = 1'b0;
      step();
      expect_eq("novalid_count", 64'(count), 64'd1);
      do_op(3'd7, 64'd99);
      expect_eq("rsvd_count", 64'(count), 64'd1);
      expect_eq("rsvd_top",   top,        64'd12);

      // POP2_PUSH with a single entry underflows
      do_op(STACK_POP2_PUSH, 64'd1);
      expect_eq("p2p_uf_trap",  64'(trap),  64'd2);
      expect_eq("p2p_uf_count", 64'(count), 64'd1);

      // fill to full, then overflow
      do_reset();
      expect_eq("clr_trap",     64'(trap),     64'd0);
      expect_eq("clr_op_ready", 64'(op_ready), 64'd1);
      for (int i = 1; i <= 16; i++) begin
         do_op(STACK_PUSH, 64'(i));
         if (i == 15) expect_eq("almost_full", 64'(full), 64'd0);
      end
      expect_eq("full_flag",  64'(full),  64'd1);
      expect_eq("full_top",   top,        64'd16);
      expect_eq("full_next",  next,       64'd15);
      expect_eq("full_count", 64'(count), 64'd16);
      do_op(STACK_PUSH, 64'd17);
      expect_eq("of_trap",     64'(trap),     64'd1);
      expect_eq("of_op_ready", 64'(op_ready), 64'd0);
      expect_eq("of_count",    64'(count),    64'd16);
      expect_eq("of_top",      top,           64'd16);
      do_op(STACK_POP, 64'd0);
      expect_eq("of_pop_count", 64'(count), 64'd16);
      expect_eq("of_pop_trap",  64'(trap),  64'd1);

      // DUP at full overflows
      do_reset();
      for (int i = 1; i <= 16; i++) do_op(STACK_PUSH, 64'(i + 100));
      do_op(STACK_DUP, 64'd0);
      expect_eq("dup_of_trap",  64'(trap),  64'd1);
      expect_eq("dup_of_count", 64'(count), 64'd16);

      // underflow from empty
      do_reset();
      do_op(STACK_DROP, 64'd0);
      expect_eq("uf_trap",     64'(trap),     64'd2);
      expect_eq("uf_count",    64'(count),    64'd0);
      expect_eq("uf_empty",    64'(empty),    64'd1);
      expect_eq("uf_op_ready", 64'(op_ready), 64'd0);
      do_op(STACK_PUSH, 64'd9);
      expect_eq("uf_push_count", 64'(count), 64'd0);
      expect_eq("uf_push_trap",  64'(trap),  64'd2);

      // DUP on empty is underflow
      do_reset();
      do_op(STACK_DUP, 64'd0);
      expect_eq("dup_uf_trap", 64'(trap), 64'd2);

      // unary op sequence
      do_reset();
      do_op(STACK_PUSH, 64'd3);
      do_op(STACK_DUP, 64'd0);
      expect_eq("dup_top",   top,  64'd3);
      expect_eq("dup_next",  next, 64'd3);
      do_op(STACK_REPLACE, 64'd4);
      expect_eq("rep_count", 64'(count), 64'd2);
      expect_eq("rep_top",   top,        64'd4);
      expect_eq("rep_next",  next,       64'd3);
      expect_eq("rep_trap",  64'(trap),  64'd0);

      // async reset mid-cycle with a push pending
      do_reset();
      do_op(STACK_PUSH, 64'd1);
      do_op(STACK_PUSH, 64'd2);
      drive(STACK_PUSH, 64'd99);
      #2;
      reset = 1'b0;
      #1;
      expect_eq("async_count", 64'(count), 64'd0);
      expect_eq("async_empty", 64'(empty), 64'd1);
      expect_eq("async_top",   top,        64'd0);
      @(posedge clk);
      #1;
      expect_eq("async_hold_count", 64'(count), 64'd0);
      @(negedge clk);
      reset   = 1'b1;
      data_in = 64'd8;
      step();
      expect_eq("post_rst_top",   top,        64'd8);
      expect_eq("post_rst_count", 64'(count), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- WebAssembly operand (value) stack sitting directly beside the cpu execute stage.
- Execute pushes immediates and results, pops operands, and discards values (drop).
- It exposes the top of stack as the cpu result word and the empty flag as result_empty.
- It raises a sticky trap code on overflow or underflow, which the cpu forwards on its trap port.

Parameters:
- WIDTH, 64, bits per stack entry (i64/f64 native; i32 zero-extended by the caller).
- DEPTH_LOG2, 4, log2 of the number of entries (default 16 entries).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  3  operation code; encodings listed under Behaviour.
- op_valid  in  1  op is executed this cycle when high.
- op_ready  out  1  high when no trap is latched; low after a trap.
- data_in  in  WIDTH  value to push (PUSH, REPLACE, POP2_PUSH).
- top  out  WIDTH  entry at sp-1; 0 when empty.
- next  out  WIDTH  entry at sp-2; 0 when fewer than 2 entries.
- count  out  DEPTH_LOG2+1  number of valid entries.
- empty  out  1  count == 0.
- full  out  1  count == 2**DEPTH_LOG2.
- trap  out  3  0 none, 3'd1 stack overflow, 3'd2 stack underflow; sticky.

Behaviour:
- Reset (asserted low, async): count=0, trap=0, empty=1, full=0, op_ready=1, top=0, next=0. Storage array is not reset.
- Op encodings:
  - 0 NOP: no effect.
  - 1 PUSH: needs count < DEPTH. mem[count] <= data_in; count+1.
  - 2 POP: needs count >= 1. count-1. The value is read from top in the same cycle, before the edge.
  - 3 DROP: needs count >= 1. count-1. Identical state effect to POP; kept distinct for tracing and coverage.
  - 4 REPLACE: needs count >= 1. mem[count-1] <= data_in; count unchanged. Used for unary ops.
  - 5 POP2_PUSH: needs count >= 2. mem[count-2] <= data_in; count-1. Used for binary ops; operands are read from top/next before the edge.
  - 6 DUP: needs 1 <= count < DEPTH. mem[count] <= top; count+1.
  - 7: reserved, treated as NOP.
- Latency: single cycle. top, next, count, empty and full reflect the new state one cycle after the op edge. top and next are combinational reads of the array at the current count.
- Overflow: PUSH or DUP with count == DEPTH. trap <= 1; count and storage unchanged.
- Underflow: any op whose minimum count is not met. trap <= 2; count and storage unchanged.
  - DUP on an empty stack is underflow, not overflow.
- Once trap != 0: op_ready=0, all further ops are ignored and trap holds. Only reset clears it.
- op_valid=0: no state change regardless of op.
- Wrap-around: count never wraps. At DEPTH, PUSH traps rather than overwriting; at 0, POP traps rather than going negative.
- Boundary cases:
  - full: PUSH at count DEPTH-1 succeeds and sets full; the next PUSH traps.
  - empty: DROP at count 1 sets empty and top reads 0.
- Reset mid-operation: async assertion forces reset values immediately, even with op_valid high. After deassertion the first op is honoured on the next rising edge.

Decomposition:
- Shared package/header (stack_defs.vh, next to assert.vh) holds:
  - op encodings: STACK_NOP..STACK_DUP.
  - trap codes: TRAP_NONE=0, TRAP_STACK_OVERFLOW=1, TRAP_STACK_UNDERFLOW=2. The same trap code values are used by the cpu trap port.
- One natural sub-module: stack_ram. A DEPTH x WIDTH flop array with one write port and two asynchronous read ports (addresses count-1 and count-2).
- operand_stack holds the count register, op legality checks and the trap latch.

Test Plan:
- Reset, then PUSH 64'h2A, then DROP -> after PUSH: top=64'h2A, count=1, empty=0. After DROP: count=0, empty=1, top=0, trap=0.
- PUSH 5, PUSH 7, POP2_PUSH with data_in=12 -> count=1, top=12, next=0. Before the edge, top=7 and next=5 were visible.
- PUSH 16 values 1..16 -> full=1, top=16. A 17th PUSH -> trap=1, op_ready=0, count=16, top=16. A following POP is ignored: count stays 16.
- From reset, DROP -> trap=2, count=0, empty=1. Then PUSH 9 is ignored: count=0 and trap stays 2.
- PUSH 3, DUP, REPLACE with data_in=4 -> count=2, top=4, next=3.
- PUSH 1, PUSH 2, then assert reset low mid-cycle with op_valid=1 and op=PUSH -> count=0, empty=1 immediately, without waiting for clk. After release, PUSH 8 -> top=8, count=1.
